// File: rtl/cypherdb_op_responder_pkg.sv
// ---------------------------------------------------------------------------
// cypherdb_op_responder_pkg
//   Shared definitions for the CypherDB operation responder:
//   - default widths for register indices and engine data
//   - default engine timeout and counter width
//   - responder FSM state encoding (IDLE=0, REQ=1, WAIT=2)
// ---------------------------------------------------------------------------
package cypherdb_op_responder_pkg;

  // Register index width (OR1200 GPR file has 32 entries)
  localparam int CDB_AW      = 5;
  // Engine result / register writeback width
  localparam int CDB_DW      = 32;
  // Number of WAIT cycles allowed for eng_done before aborting
  localparam int CDB_TIMEOUT = 16;
  // Timeout counter width; must be able to hold CDB_TIMEOUT-1
  localparam int CDB_TW      = 5;

  // State codes are fixed so they line up with the legacy shared defines
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Minimum counter width able to hold (timeout - 1), never below 1 bit
  function automatic int min_tw(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cypherdb_op_responder_if.sv
// ---------------------------------------------------------------------------
// cypherdb_op_responder_if
//   Bundles the three sides of the responder:
//   - start side     : start_pulse, cache_ra, cache_rb
//   - engine side    : eng_req, eng_ra, eng_rb, eng_ack, eng_done, eng_result
//   - writeback side : wb_en, wb_addr, wb_data, done_pulse
//   - status         : timeout_err, overrun, resp_stall
//   slave  : the responder itself (drives engine request and writeback)
//   master : whatever surrounds it (pulse generator, engine, register file)
// ---------------------------------------------------------------------------
interface cypherdb_op_responder_if
  import cypherdb_op_responder_pkg::*;
#(
  parameter int AW = CDB_AW,
  parameter int DW = CDB_DW
);

  logic          start_pulse;
  logic [AW-1:0] cache_ra;
  logic [AW-1:0] cache_rb;

  logic          eng_req;
  logic [AW-1:0] eng_ra;
  logic [AW-1:0] eng_rb;
  logic          eng_ack;
  logic          eng_done;
  logic [DW-1:0] eng_result;

  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          done_pulse;

  logic          timeout_err;
  logic          overrun;
  logic          resp_stall;

  modport slave (
    input  start_pulse, cache_ra, cache_rb,
    input  eng_ack, eng_done, eng_result,
    output eng_req, eng_ra, eng_rb,
    output wb_en, wb_addr, wb_data, done_pulse,
    output timeout_err, overrun, resp_stall
  );

  modport master (
    output start_pulse, cache_ra, cache_rb,
    output eng_ack, eng_done, eng_result,
    input  eng_req, eng_ra, eng_rb,
    input  wb_en, wb_addr, wb_data, done_pulse,
    input  timeout_err, overrun, resp_stall
  );

endinterface

// File: rtl/cypherdb_timeout_ctr.sv
// ---------------------------------------------------------------------------
// cypherdb_timeout_ctr
//   Loadable down-counter used to bound the wait for the engine result.
//   Ports:
//     clk       in   system clock
//     rst       in   synchronous, active-low reset (count -> 0)
//     load      in   load count from load_val (has priority over dec)
//     load_val  in   TW-bit value to load
//     dec       in   decrement by one; saturates at zero
//     zero      out  count == 0 (decoded from the count register)
// ---------------------------------------------------------------------------
module cypherdb_timeout_ctr #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [TW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/cypherdb_op_responder.sv
// ---------------------------------------------------------------------------
// cypherdb_op_responder
//   Receives the one-cycle CypherDB start pulse with the captured ra/rb
//   indices, runs a req/ack handshake with the crypto engine, waits a
//   bounded number of cycles for the engine result and then issues a
//   one-cycle register-file writeback together with a done pulse. The
//   pipeline is stalled (resp_stall) for as long as the FSM is not idle.
//
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous, active-low reset
//     bus   slave modport of cypherdb_op_responder_if:
//           start_pulse/cache_ra/cache_rb   start request from pulse generator
//           eng_req/eng_ra/eng_rb           request to engine, held until ack
//           eng_ack/eng_done/eng_result     engine handshake and result
//           wb_en/wb_addr/wb_data           one-cycle register writeback
//           done_pulse                      one-cycle completion with wb_en
//           timeout_err                     one-cycle pulse on timeout abort
//           overrun                         sticky: start seen while busy
//           resp_stall                      high whenever state != IDLE
//
//   All outputs are registered except resp_stall, which is decoded from
//   the state register so the stall releases in the same cycle the
//   writeback pulse appears.
// ---------------------------------------------------------------------------
module cypherdb_op_responder
  import cypherdb_op_responder_pkg::*;
#(
  parameter int DW      = CDB_DW,
  parameter int AW      = CDB_AW,
  parameter int TIMEOUT = CDB_TIMEOUT,
  parameter int TW      = CDB_TW
) (
  input  logic                     clk,
  input  logic                     rst,
  cypherdb_op_responder_if.slave   bus
);

  // Counter starts at TIMEOUT-1 so that the counter==0 cycle is the
  // TIMEOUT-th WAIT cycle, giving exactly TIMEOUT chances for eng_done.
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);

  state_t        state_reg;
  logic          eng_req_reg;
  logic [AW-1:0] eng_ra_reg;
  logic [AW-1:0] eng_rb_reg;
  logic          wb_en_reg;
  logic [AW-1:0] wb_addr_reg;
  logic [DW-1:0] wb_data_reg;
  logic          done_pulse_reg;
  logic          timeout_err_reg;
  logic          overrun_reg;

  logic          ctr_load;
  logic          ctr_dec;
  logic          ctr_zero;

  // Load on the ack that moves REQ -> WAIT; count down every WAIT cycle
  // that has no result. Loading on an ack+done cycle is harmless because
  // the FSM leaves straight for IDLE and never looks at the count.
  assign ctr_load = (state_reg == ST_REQ) && bus.eng_ack;
  assign ctr_dec  = (state_reg == ST_WAIT) && !bus.eng_done;

  cypherdb_timeout_ctr #(
    .TW (TW)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (TO_LOAD),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      eng_req_reg     <= 1'b0;
      eng_ra_reg      <= '0;
      eng_rb_reg      <= '0;
      wb_en_reg       <= 1'b0;
      wb_addr_reg     <= '0;
      wb_data_reg     <= '0;
      done_pulse_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      // Pulse outputs default low so each assertion lasts one cycle
      wb_en_reg       <= 1'b0;
      done_pulse_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;

      // A start while busy is dropped, but remembered until reset
      if (bus.start_pulse && (state_reg != ST_IDLE)) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (bus.start_pulse) begin
            eng_ra_reg  <= bus.cache_ra;
            eng_rb_reg  <= bus.cache_rb;
            eng_req_reg <= 1'b1;
            state_reg   <= ST_REQ;
          end
        end

        ST_REQ: begin
          // No timeout here: the engine is required to acknowledge
          if (bus.eng_ack) begin
            eng_req_reg <= 1'b0;
            if (bus.eng_done) begin
              // Result arrived with the ack: skip WAIT entirely
              wb_data_reg    <= bus.eng_result;
              wb_addr_reg    <= eng_ra_reg;
              wb_en_reg      <= 1'b1;
              done_pulse_reg <= 1'b1;
              state_reg      <= ST_IDLE;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          // eng_done takes priority over the final (counter==0) cycle
          if (bus.eng_done) begin
            wb_data_reg    <= bus.eng_result;
            wb_addr_reg    <= eng_ra_reg;
            wb_en_reg      <= 1'b1;
            done_pulse_reg <= 1'b1;
            state_reg      <= ST_IDLE;
          end else if (ctr_zero) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_IDLE;
          end
        end

        default: begin
          eng_req_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.eng_req     = eng_req_reg;
  assign bus.eng_ra      = eng_ra_reg;
  assign bus.eng_rb      = eng_rb_reg;
  assign bus.wb_en       = wb_en_reg;
  assign bus.wb_addr     = wb_addr_reg;
  assign bus.wb_data     = wb_data_reg;
  assign bus.done_pulse  = done_pulse_reg;
  assign bus.timeout_err = timeout_err_reg;
  assign bus.overrun     = overrun_reg;
  assign bus.resp_stall  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cypherdb_op_responder.sv
// ---------------------------------------------------------------------------
// tb_cypherdb_op_responder
//   Directed stimulus issues operations and pushes the expected response
//   (writeback with addr/data, or timeout) into a scoreboard queue. A
//   monitor pops and compares whenever wb_en, done_pulse or timeout_err is
//   seen. Inline checks cover reset values, handshake timing and status.
// ---------------------------------------------------------------------------
module tb_cypherdb_op_responder;

  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 16;
  localparam int TW      = 5;

  typedef struct {
    bit            is_wb;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic rst;

  cypherdb_op_responder_if #(.AW(AW), .DW(DW)) bus_if ();

  cypherdb_op_responder #(
    .DW      (DW),
    .AW      (AW),
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus_if.wb_en || bus_if.done_pulse || bus_if.timeout_err) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: actual wb_en=%0b done=%0b timeout=%0b required no response",
                 bus_if.wb_en, bus_if.done_pulse, bus_if.timeout_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("resp @%0t: wb_en=%0b done=%0b timeout=%0b addr=%0d data=%08h",
                 $time, bus_if.wb_en, bus_if.done_pulse, bus_if.timeout_err,
                 bus_if.wb_addr, bus_if.wb_data);
        chk("resp_wb_en", bus_if.wb_en, e.is_wb);
        chk("resp_done_pulse", bus_if.done_pulse, e.is_wb);
        chk("resp_timeout_err", bus_if.timeout_err, !e.is_wb);
        if (e.is_wb) begin
          chk("resp_wb_addr", bus_if.wb_addr, e.addr);
          chk("resp_wb_data", bus_if.wb_data, e.data);
        end
      end
    end
  end

  // One full operation. ack_wait: REQ cycles before ack. done_wait: WAIT
  // cycles without done before done is raised (>= TIMEOUT means never).
  task automatic do_op(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input int ack_wait, input int done_wait,
                       input logic [DW-1:0] res, input bit same_cycle);
    bus_if.start_pulse = 1'b1;
    bus_if.cache_ra    = ra;
    bus_if.cache_rb    = rb;
    tick();
    bus_if.start_pulse = 1'b0;
    bus_if.cache_ra    = ~ra;
    bus_if.cache_rb    = ~rb;
    chk("req_after_start", bus_if.eng_req, 1);
    chk("stall_in_req", bus_if.resp_stall, 1);
    chk("eng_ra_latched", bus_if.eng_ra, ra);
    chk("eng_rb_latched", bus_if.eng_rb, rb);
    for (int i = 0; i < ack_wait; i++) begin
      tick();
      chk("req_held", bus_if.eng_req, 1);
      chk("ra_stable", bus_if.eng_ra, ra);
      chk("rb_stable", bus_if.eng_rb, rb);
      chk("no_timeout_in_req", bus_if.timeout_err, 0);
    end
    bus_if.eng_ack = 1'b1;
    if (same_cycle) begin
      bus_if.eng_done   = 1'b1;
      bus_if.eng_result = res;
      exp_q.push_back('{is_wb: 1'b1, addr: ra, data: res});
      tick();
      bus_if.eng_ack  = 1'b0;
      bus_if.eng_done = 1'b0;
      chk("req_drop_same_cycle", bus_if.eng_req, 0);
      chk("idle_after_same_cycle", bus_if.resp_stall, 0);
      return;
    end
    tick();
    bus_if.eng_ack = 1'b0;
    chk("req_drop_on_ack", bus_if.eng_req, 0);
    chk("stall_in_wait", bus_if.resp_stall, 1);
    if (done_wait >= TIMEOUT) begin
      exp_q.push_back('{is_wb: 1'b0, addr: '0, data: '0});
      // timeout_err appears exactly TIMEOUT cycles after WAIT entry
      for (int i = 1; i <= TIMEOUT; i++) begin
        tick();
        chk("timeout_timing", bus_if.timeout_err, (i == TIMEOUT));
      end
      chk("idle_after_timeout", bus_if.resp_stall, 0);
    end else begin
      for (int i = 0; i < done_wait; i++) tick();
      bus_if.eng_done   = 1'b1;
      bus_if.eng_result = res;
      exp_q.push_back('{is_wb: 1'b1, addr: ra, data: res});
      tick();
      bus_if.eng_done = 1'b0;
      chk("wb_after_done", bus_if.wb_en, 1);
      chk("idle_after_done", bus_if.resp_stall, 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_eng_req"}, bus_if.eng_req, 0);
    chk({tag, "_eng_ra"}, bus_if.eng_ra, 0);
    chk({tag, "_eng_rb"}, bus_if.eng_rb, 0);
    chk({tag, "_wb_en"}, bus_if.wb_en, 0);
    chk({tag, "_wb_addr"}, bus_if.wb_addr, 0);
    chk({tag, "_wb_data"}, bus_if.wb_data, 0);
    chk({tag, "_done_pulse"}, bus_if.done_pulse, 0);
    chk({tag, "_timeout_err"}, bus_if.timeout_err, 0);
    chk({tag, "_overrun"}, bus_if.overrun, 0);
    chk({tag, "_resp_stall"}, bus_if.resp_stall, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=time_expired required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                = 1'b0;
    bus_if.start_pulse = 1'b0;
    bus_if.cache_ra    = '0;
    bus_if.cache_rb    = '0;
    bus_if.eng_ack     = 1'b0;
    bus_if.eng_done    = 1'b0;
    bus_if.eng_result  = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // 1: basic, ack and done one cycle apart each
    do_op(5'd3, 5'd7, 0, 0, 32'hDEADBEEF, 1'b0);
    tick();

    // 2: ack held off 10 cycles
    do_op(5'd3, 5'd7, 10, 0, 32'h0000_1111, 1'b0);
    tick();

    // 3: timeout with no done
    do_op(5'd4, 5'd8, 1, TIMEOUT, 32'h0, 1'b0);
    chk("no_wb_on_timeout", bus_if.wb_en, 0);
    tick();

    // 4: done on the last allowed WAIT cycle, then ack+done together
    do_op(5'd17, 5'd2, 0, TIMEOUT - 1, 32'h8000_0001, 1'b0);
    chk("no_timeout_on_edge_done", bus_if.timeout_err, 0);
    tick();
    do_op(5'd31, 5'd30, 2, 0, 32'h1234_ABCD, 1'b1);
    tick();

    // eng_done while idle is ignored
    bus_if.eng_done   = 1'b1;
    bus_if.eng_result = 32'hFFFF_FFFF;
    tick();
    bus_if.eng_done = 1'b0;
    chk("idle_done_ignored_stall", bus_if.resp_stall, 0);
    chk("overrun_clear_before", bus_if.overrun, 0);
    tick();

    // 5: overrun during WAIT, then start next to wb_en accepted
    bus_if.start_pulse = 1'b1;
    bus_if.cache_ra    = 5'd3;
    bus_if.cache_rb    = 5'd7;
    tick();
    bus_if.start_pulse = 1'b0;
    bus_if.eng_ack     = 1'b1;
    tick();
    bus_if.eng_ack = 1'b0;
    tick();
    bus_if.start_pulse = 1'b1;
    bus_if.cache_ra    = 5'd9;
    bus_if.cache_rb    = 5'd2;
    tick();
    bus_if.start_pulse = 1'b0;
    chk("overrun_set", bus_if.overrun, 1);
    chk("overrun_no_relatch_ra", bus_if.eng_ra, 3);
    chk("overrun_no_relatch_rb", bus_if.eng_rb, 7);
    chk("overrun_still_busy", bus_if.resp_stall, 1);
    bus_if.eng_done   = 1'b1;
    bus_if.eng_result = 32'h1234_5678;
    exp_q.push_back('{is_wb: 1'b1, addr: 5'd3, data: 32'h1234_5678});
    tick();
    bus_if.eng_done    = 1'b0;
    bus_if.start_pulse = 1'b1;
    bus_if.cache_ra    = 5'd12;
    bus_if.cache_rb    = 5'd1;
    tick();
    bus_if.start_pulse = 1'b0;
    chk("back_to_back_req", bus_if.eng_req, 1);
    chk("back_to_back_ra", bus_if.eng_ra, 12);
    chk("back_to_back_rb", bus_if.eng_rb, 1);
    bus_if.eng_ack    = 1'b1;
    bus_if.eng_done   = 1'b1;
    bus_if.eng_result = 32'hCAFE_F00D;
    exp_q.push_back('{is_wb: 1'b1, addr: 5'd12, data: 32'hCAFE_F00D});
    tick();
    bus_if.eng_ack  = 1'b0;
    bus_if.eng_done = 1'b0;
    tick();
    chk("overrun_sticky", bus_if.overrun, 1);

    // 6: reset in WAIT aborts silently, then a normal operation
    bus_if.start_pulse = 1'b1;
    bus_if.cache_ra    = 5'd5;
    bus_if.cache_rb    = 5'd6;
    tick();
    bus_if.start_pulse = 1'b0;
    bus_if.eng_ack     = 1'b1;
    tick();
    bus_if.eng_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all_zero("midreset");
    rst = 1'b1;
    tick();
    tick();
    chk("post_reset_idle", bus_if.resp_stall, 0);
    do_op(5'd21, 5'd10, 0, 0, 32'hA5A5_5A5A, 1'b0);
    tick();
    tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
